// File: rtl/jpeg_bitstream_reader.sv
// JPEG entropy-segment reader: strips 0xFF/0x00 stuffing and 0xFF fill, stalls on markers,
// and exposes an MSB-aligned peek window with variable-length consume. Macro: JPEG_STUFF_STATS_EN.
module jpeg_bitstream_reader #(
    parameter int BUF_W  = 32,
    parameter int PEEK_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [PEEK_W-1:0] peek,
    output logic [5:0]        bits_avail,
    input  logic              consume_en,
    input  logic [4:0]        consume_n,
    output logic              consume_err,
    output logic              marker_valid,
    output logic [7:0]        marker_code,
    input  logic              marker_ack,
    output logic [23:0]       byte_count,
    output logic [15:0]       stuff_cnt,
    output logic [1:0]        state_dbg
);

    // Handshake: a byte transfers on a rising edge where byte_valid and byte_ready are both high;
    // byte_ready is a function of registered state only and never of this cycle's consume.

    typedef enum logic [1:0] {
        S_DATA   = 2'd0,
        S_FF     = 2'd1,
        S_MARKER = 2'd2
    } state_t;

    localparam logic [5:0] PEEK_MAX = 6'(PEEK_W);
    localparam logic [5:0] FILL_MAX = 6'(BUF_W - 8);

    state_t             state;
    logic [BUF_W-1:0]   acc;
    logic               accept;
    logic               ack;
    logic               consume_ok;
    logic               append;
    logic [7:0]         append_byte;
    logic [5:0]         shift_n;
    logic [5:0]         avail_kept;
    logic [BUF_W-1:0]   acc_kept;
    logic [BUF_W-1:0]   append_word;
    logic [PEEK_W-1:0]  fill_mask;

    assign byte_ready   = !rst && (state != S_MARKER) && (bits_avail <= FILL_MAX);
    assign marker_valid = (state == S_MARKER);
    assign state_dbg    = state;

    // Bits below bits_avail are kept at zero, so OR-ing in ones gives the JPEG 1-padding.
    assign fill_mask = {PEEK_W{1'b1}} >> bits_avail;
    assign peek      = acc[BUF_W-1 -: PEEK_W] | fill_mask;

    always_comb begin
        accept      = byte_valid & byte_ready;
        ack         = marker_ack & (state == S_MARKER);
        consume_ok  = consume_en && (consume_n != 5'd0) &&
                      ({1'b0, consume_n} <= PEEK_MAX) && ({1'b0, consume_n} <= bits_avail);
        shift_n     = (consume_ok && !ack) ? {1'b0, consume_n} : 6'd0;
        acc_kept    = acc << shift_n;
        avail_kept  = bits_avail - shift_n;
        append      = 1'b0;
        append_byte = byte_in;
        if (accept) begin
            case (state)
                S_DATA: append = (byte_in != 8'hFF);
                S_FF: begin
                    append      = (byte_in == 8'h00);
                    append_byte = 8'hFF;
                end
                default: append = 1'b0;
            endcase
        end
        // New byte lands directly below whatever survives this cycle's consume.
        append_word = {append_byte, {(BUF_W-8){1'b0}}} >> avail_kept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_DATA;
            acc         <= '0;
            bits_avail  <= '0;
            marker_code <= 8'h00;
            consume_err <= 1'b0;
            byte_count  <= 24'd0;
        end else begin
            consume_err <= consume_en && !consume_ok && !ack;
            if (accept) begin
                byte_count <= byte_count + 24'd1;
            end
            if (ack) begin
                acc        <= '0;
                bits_avail <= '0;
            end else if (append) begin
                acc        <= acc_kept | append_word;
                bits_avail <= avail_kept + 6'd8;
            end else begin
                acc        <= acc_kept;
                bits_avail <= avail_kept;
            end
            case (state)
                S_DATA: begin
                    if (accept && byte_in == 8'hFF) begin
                        state <= S_FF;
                    end
                end
                S_FF: begin
                    if (accept) begin
                        if (byte_in == 8'h00) begin
                            state <= S_DATA;
                        end else if (byte_in != 8'hFF) begin
                            marker_code <= byte_in;
                            state       <= S_MARKER;
                        end
                    end
                end
                S_MARKER: begin
                    if (ack) begin
                        state <= S_DATA;
                    end
                end
                default: state <= S_DATA;
            endcase
        end
    end

`ifdef JPEG_STUFF_STATS_EN
    logic [15:0] stuff_q;
    logic        stuff_hit;

    assign stuff_hit = accept && (state == S_FF) && (byte_in == 8'h00);
    assign stuff_cnt = stuff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stuff_q <= 16'd0;
        end else if (stuff_hit && stuff_q != 16'hFFFF) begin
            stuff_q <= stuff_q + 16'd1;
        end
    end
`else
    assign stuff_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_jpeg_bitstream_reader.sv
// Bench for jpeg_bitstream_reader: directed scenarios plus randomized traffic against a bit-queue model.
module tb_jpeg_bitstream_reader;

    localparam int BUF_W  = 32;
    localparam int PEEK_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [PEEK_W-1:0] peek;
    logic [5:0]        bits_avail;
    logic              consume_en;
    logic [4:0]        consume_n;
    logic              consume_err;
    logic              marker_valid;
    logic [7:0]        marker_code;
    logic              marker_ack;
    logic [23:0]       byte_count;
    logic [15:0]       stuff_cnt;
    logic [1:0]        state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: decoded bit stream as a queue, plus the stuffing parser flags.
    bit          mq[$];
    bit          m_prev_ff;
    bit          m_in_marker;
    logic [7:0]  m_code;
    logic [23:0] m_count;
    logic [15:0] m_stuff;
    logic        m_err;

    jpeg_bitstream_reader #(.BUF_W(BUF_W), .PEEK_W(PEEK_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .peek         (peek),
        .bits_avail   (bits_avail),
        .consume_en   (consume_en),
        .consume_n    (consume_n),
        .consume_err  (consume_err),
        .marker_valid (marker_valid),
        .marker_code  (marker_code),
        .marker_ack   (marker_ack),
        .byte_count   (byte_count),
        .stuff_cnt    (stuff_cnt),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] exp_stuff();
`ifdef JPEG_STUFF_STATS_EN
        return m_stuff;
`else
        return 16'd0;
`endif
    endfunction

    function automatic logic [PEEK_W-1:0] model_peek();
        logic [PEEK_W-1:0] p;
        for (int i = 0; i < PEEK_W; i++) begin
            p[PEEK_W-1-i] = (i < mq.size()) ? mq[i] : 1'b1;
        end
        return p;
    endfunction

    function automatic logic model_ready();
        return !m_in_marker && (mq.size() <= BUF_W - 8);
    endfunction

    task automatic model_clear();
        mq.delete();
        m_prev_ff   = 1'b0;
        m_in_marker = 1'b0;
        m_code      = 8'h00;
        m_count     = 24'd0;
        m_stuff     = 16'd0;
        m_err       = 1'b0;
    endtask

    task automatic model_update(input logic v, input logic [7:0] b, input logic ce,
                                input logic [4:0] cn, input logic ack);
        logic accept, ack_eff, ok;
        accept  = v && model_ready();
        ack_eff = ack && m_in_marker;
        ok      = ce && (cn >= 1) && (cn <= PEEK_W) && (cn <= mq.size());
        m_err   = ce && !ok && !ack_eff;
        if (ack_eff) begin
            mq.delete();
            m_in_marker = 1'b0;
        end else if (ok) begin
            repeat (int'(cn)) void'(mq.pop_front());
        end
        if (accept) begin
            m_count = m_count + 24'd1;
            if (m_prev_ff) begin
                if (b == 8'h00) begin
                    for (int i = 7; i >= 0; i--) mq.push_back(1'b1);
                    if (m_stuff != 16'hFFFF) m_stuff = m_stuff + 16'd1;
                    m_prev_ff = 1'b0;
                end else if (b != 8'hFF) begin
                    m_code      = b;
                    m_in_marker = 1'b1;
                    m_prev_ff   = 1'b0;
                end
            end else if (b == 8'hFF) begin
                m_prev_ff = 1'b1;
            end else begin
                for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
            end
        end
    endtask

    // Drive one cycle's inputs away from the edge, advance, then sample #1 after the edge.
    task automatic drive(input logic v, input logic [7:0] b, input logic ce,
                         input logic [4:0] cn, input logic ack);
        byte_valid = v;
        byte_in    = b;
        consume_en = ce;
        consume_n  = cn;
        marker_ack = ack;
        @(posedge clk);
        #1;
        model_update(v, b, ce, cn, ack);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        consume_en = 1'b0;
        consume_n  = 5'd0;
        marker_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (bits_avail !== 6'd0) begin tests_failed++; $display("FAIL reset_avail: got %0d expected 0", bits_avail); end
        tests_run++;
        if (peek !== 16'hFFFF) begin tests_failed++; $display("FAIL reset_peek: got %h expected ffff", peek); end
        tests_run++;
        if (marker_valid !== 1'b0 || marker_code !== 8'h00) begin
            tests_failed++; $display("FAIL reset_marker: got %b/%h expected 0/00", marker_valid, marker_code);
        end
        tests_run++;
        if (byte_count !== 24'd0 || stuff_cnt !== 16'd0 || consume_err !== 1'b0) begin
            tests_failed++; $display("FAIL reset_counts: got %0d/%0d/%b expected 0/0/0", byte_count, stuff_cnt, consume_err);
        end
        tests_run++;
        if (byte_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_after: got %b expected 1", byte_ready); end
    endtask

    task automatic test_basic();
        do_reset();
        drive(1'b1, 8'h12, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 8'h34, 1'b0, 5'd0, 1'b0);
        tests_run++;
        if (bits_avail !== 6'd16 || peek !== 16'h1234) begin
            tests_failed++; $display("FAIL basic_append: got %0d/%h expected 16/1234", bits_avail, peek);
        end
        drive(1'b0, 8'h00, 1'b1, 5'd4, 1'b0);
        tests_run++;
        if (bits_avail !== 6'd12 || peek !== 16'h234F || consume_err !== 1'b0) begin
            tests_failed++; $display("FAIL basic_consume: got %0d/%h/%b expected 12/234f/0", bits_avail, peek, consume_err);
        end
    endtask

    task automatic test_stuffing();
        logic [15:0] want_stuff;
        do_reset();
        drive(1'b1, 8'hFF, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 8'h00, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 8'hAB, 1'b0, 5'd0, 1'b0);
`ifdef JPEG_STUFF_STATS_EN
        want_stuff = 16'd1;
`else
        want_stuff = 16'd0;
`endif
        tests_run++;
        if (bits_avail !== 6'd16 || peek !== 16'hFFAB) begin
            tests_failed++; $display("FAIL stuff_data: got %0d/%h expected 16/ffab", bits_avail, peek);
        end
        tests_run++;
        if (byte_count !== 24'd3 || stuff_cnt !== want_stuff) begin
            tests_failed++; $display("FAIL stuff_counts: got %0d/%0d expected 3/%0d", byte_count, stuff_cnt, want_stuff);
        end
    endtask

    task automatic test_marker();
        do_reset();
        drive(1'b1, 8'hAB, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 8'hFF, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 8'hD9, 1'b0, 5'd0, 1'b0);
        tests_run++;
        if (marker_valid !== 1'b1 || marker_code !== 8'hD9 || byte_ready !== 1'b0) begin
            tests_failed++; $display("FAIL marker_detect: got %b/%h/%b expected 1/d9/0", marker_valid, marker_code, byte_ready);
        end
        tests_run++;
        if (bits_avail !== 6'd8 || peek !== 16'hABFF) begin
            tests_failed++; $display("FAIL marker_bits: got %0d/%h expected 8/abff", bits_avail, peek);
        end
        drive(1'b0, 8'h00, 1'b0, 5'd0, 1'b1);
        tests_run++;
        if (bits_avail !== 6'd0 || marker_valid !== 1'b0 || byte_ready !== 1'b1) begin
            tests_failed++; $display("FAIL marker_ack: got %0d/%b/%b expected 0/0/1", bits_avail, marker_valid, byte_ready);
        end
    endtask

    task automatic test_fill();
        do_reset();
        drive(1'b1, 8'hFF, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 8'hFF, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 8'hFF, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 8'hD0, 1'b0, 5'd0, 1'b0);
        tests_run++;
        if (marker_valid !== 1'b1 || marker_code !== 8'hD0) begin
            tests_failed++; $display("FAIL fill_marker: got %b/%h expected 1/d0", marker_valid, marker_code);
        end
        tests_run++;
        if (bits_avail !== 6'd0 || byte_count !== 24'd4) begin
            tests_failed++; $display("FAIL fill_bits: got %0d/%0d expected 0/4", bits_avail, byte_count);
        end
        drive(1'b0, 8'h00, 1'b0, 5'd0, 1'b1);
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, 8'h11, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 8'h22, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 8'h33, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 8'h44, 1'b0, 5'd0, 1'b0);
        tests_run++;
        if (bits_avail !== 6'd32 || byte_ready !== 1'b0 || peek !== 16'h1122) begin
            tests_failed++; $display("FAIL bp_full: got %0d/%b/%h expected 32/0/1122", bits_avail, byte_ready, peek);
        end
        drive(1'b1, 8'h55, 1'b1, 5'd8, 1'b0);
        tests_run++;
        if (bits_avail !== 6'd24 || byte_ready !== 1'b1 || byte_count !== 24'd4) begin
            tests_failed++; $display("FAIL bp_stall: got %0d/%b/%0d expected 24/1/4", bits_avail, byte_ready, byte_count);
        end
        drive(1'b1, 8'h55, 1'b0, 5'd0, 1'b0);
        tests_run++;
        if (bits_avail !== 6'd32 || byte_count !== 24'd5 || peek !== 16'h2233) begin
            tests_failed++; $display("FAIL bp_fifth: got %0d/%0d/%h expected 32/5/2233", bits_avail, byte_count, peek);
        end
        drive(1'b0, 8'h00, 1'b1, 5'd8, 1'b0);
        drive(1'b1, 8'h66, 1'b1, 5'd8, 1'b0);
        tests_run++;
        if (bits_avail !== 6'd24 || peek !== 16'h4455) begin
            tests_failed++; $display("FAIL bp_simul: got %0d/%h expected 24/4455", bits_avail, peek);
        end
    endtask

    task automatic test_consume_err();
        do_reset();
        drive(1'b1, 8'hA5, 1'b0, 5'd0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 5'd5, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 5'd5, 1'b0);
        tests_run++;
        if (consume_err !== 1'b1 || bits_avail !== 6'd3 || peek !== 16'hBFFF) begin
            tests_failed++; $display("FAIL err_short: got %b/%0d/%h expected 1/3/bfff", consume_err, bits_avail, peek);
        end
        drive(1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
        tests_run++;
        if (consume_err !== 1'b0 || bits_avail !== 6'd3) begin
            tests_failed++; $display("FAIL err_pulse: got %b/%0d expected 0/3", consume_err, bits_avail);
        end
        drive(1'b0, 8'h00, 1'b1, 5'd0, 1'b0);
        tests_run++;
        if (consume_err !== 1'b1 || bits_avail !== 6'd3) begin
            tests_failed++; $display("FAIL err_zero: got %b/%0d expected 1/3", consume_err, bits_avail);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 8'hAB, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 8'hFF, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 8'hD9, 1'b0, 5'd0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 5'd20, 1'b0);
        byte_valid = 1'b0;
        consume_en = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bits_avail !== 6'd0 || peek !== 16'hFFFF || byte_ready !== 1'b0) begin
            tests_failed++; $display("FAIL arst_data: got %0d/%h/%b expected 0/ffff/0", bits_avail, peek, byte_ready);
        end
        tests_run++;
        if (marker_valid !== 1'b0 || marker_code !== 8'h00 || consume_err !== 1'b0 || byte_count !== 24'd0) begin
            tests_failed++;
            $display("FAIL arst_ctrl: got %b/%h/%b/%0d expected 0/00/0/0", marker_valid, marker_code, consume_err, byte_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
        tests_run++;
        if (byte_ready !== 1'b1 || marker_valid !== 1'b0) begin
            tests_failed++; $display("FAIL arst_release: got %b/%b expected 1/0", byte_ready, marker_valid);
        end
    endtask

    task automatic test_random();
        logic       v, ce, ack;
        logic [7:0] b;
        logic [4:0] cn;
        int         r;
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            v  = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 9);
            b  = (r < 3) ? 8'hFF : (r < 5) ? 8'h00 : 8'($urandom_range(0, 255));
            ce = $urandom_range(0, 1) != 0;
            cn = 5'($urandom_range(0, 18));
            ack = m_in_marker ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            drive(v, b, ce, cn, ack);
            tests_run++;
            if (bits_avail !== 6'(mq.size())) begin
                tests_failed++; $display("FAIL rnd_avail[%0d]: got %0d expected %0d", cyc, bits_avail, mq.size());
            end
            tests_run++;
            if (peek !== model_peek()) begin
                tests_failed++; $display("FAIL rnd_peek[%0d]: got %h expected %h", cyc, peek, model_peek());
            end
            tests_run++;
            if (byte_ready !== model_ready() || marker_valid !== m_in_marker) begin
                tests_failed++;
                $display("FAIL rnd_flow[%0d]: got %b/%b expected %b/%b", cyc, byte_ready, marker_valid, model_ready(), m_in_marker);
            end
            tests_run++;
            if (marker_code !== m_code || consume_err !== m_err) begin
                tests_failed++;
                $display("FAIL rnd_marker_err[%0d]: got %h/%b expected %h/%b", cyc, marker_code, consume_err, m_code, m_err);
            end
            tests_run++;
            if (byte_count !== m_count || stuff_cnt !== exp_stuff()) begin
                tests_failed++;
                $display("FAIL rnd_counts[%0d]: got %0d/%0d expected %0d/%0d", cyc, byte_count, stuff_cnt, m_count, exp_stuff());
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_stuffing();
        test_marker();
        test_fill();
        test_backpressure();
        test_consume_err();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/jpeg_bitstream_reader.md
Name: jpeg_bitstream_reader

Overview:
Decoder-side front end for the entropy-coded segment produced by jpeg_top and JpegEnc. It accepts the compressed byte stream, removes 0xFF/0x00 byte stuffing and discards 0xFF fill bytes. It detects markers and presents an MSB-aligned bit window with a variable-length consume handshake for a downstream Huffman decoder. It is the reader counterpart of the encoder's bit packer and stuffer.

Parameters:
BUF_W, 32, bit accumulator width; must satisfy BUF_W >= PEEK_W + 8.
PEEK_W, 16, width of the peek window (maximum bits consumed per cycle).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
byte_in  in  8  compressed stream byte
byte_valid  in  1  byte_in is valid
byte_ready  out  1  block accepts byte_in this cycle
peek  out  PEEK_W  next unconsumed bits, MSB first
bits_avail  out  6  number of valid bits in the accumulator (0..BUF_W)
consume_en  in  1  request to drop consume_n bits
consume_n  in  5  bits to drop (1..PEEK_W)
consume_err  out  1  one-cycle pulse: consume request rejected
marker_valid  out  1  marker detected; input stalled
marker_code  out  8  second byte of the detected marker
marker_ack  in  1  release the marker and flush the accumulator
byte_count  out  24  accepted input bytes, including stuff, fill and marker bytes
stuff_cnt  out  16  stuffed 0x00 bytes removed (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state S_DATA, accumulator cleared, bits_avail=0, peek=all ones, marker_valid=0, marker_code=0x00, consume_err=0, byte_count=0, stuff_cnt=0, byte_ready=0 while rst is high.
- Byte transfer occurs when byte_valid & byte_ready are both high at a rising edge.
- byte_ready = !rst & (state != S_MARKER) & (bits_avail <= BUF_W-8). It depends only on registered state, with no consume look-ahead.
- State machine:
  - S_DATA:
    - byte != 0xFF: append 8 bits, stay in S_DATA.
    - byte == 0xFF: append nothing, go to S_FF.
  - S_FF:
    - byte == 0x00: append 0xFF, stuff_cnt+1, go to S_DATA.
    - byte == 0xFF: fill byte; append nothing, stay in S_FF.
    - any other byte: marker_code <= byte, go to S_MARKER.
  - S_MARKER:
    - marker_valid=1, byte_ready=0.
    - Consumes remain legal, so the decoder can drain bits ahead of the marker.
    - marker_ack: bits_avail <= 0 (discards the pad bits) and go to S_DATA. marker_valid drops on the next cycle.
    - marker_ack outside S_MARKER is ignored.
- Latency: an accepted byte is reflected in bits_avail and peek on the cycle after the accepting edge.
- peek = accumulator bits [top .. top-PEEK_W+1]. Positions at or beyond bits_avail read as 1, matching JPEG 1-padding.
- Consume:
  - If consume_en & 1 <= consume_n <= min(PEEK_W, bits_avail): shift left by consume_n.
  - Otherwise, when consume_en is high: no change and consume_err=1 for one cycle. This covers consume_n = 0 and consume_n > PEEK_W.
- Simultaneous append and consume in one cycle: bits_avail_next = bits_avail - consume_n + 8. The appended byte lands directly below the remaining bits.
- Simultaneous marker_ack and consume: the ack wins; bits_avail becomes 0 and no consume_err is raised.
- byte_count wraps modulo 2^24.
- stuff_cnt saturates at 0xFFFF.
- Reset mid-stream: all state is lost immediately. There is no resynchronisation; the source restarts at a byte boundary.

Optional Feature:
JPEG_STUFF_STATS_EN
- Defined: stuff_cnt counts removed 0x00 stuff bytes as described above.
- Undefined: the stuff_cnt port remains present and is tied to 0, and its counter logic is omitted.
- All other behaviour is identical in both builds.

Test Plan:
1. Feed 0x12, 0x34 → bits_avail=16, peek=0x1234. Then consume_n=4 → bits_avail=12, peek=0x234F.
2. Feed 0xFF, 0x00, 0xAB → bits_avail=16, peek=0xFFAB, byte_count=3, stuff_cnt=1 (0 without JPEG_STUFF_STATS_EN).
3. Feed 0xAB, 0xFF, 0xD9 → marker_valid=1, marker_code=0xD9, byte_ready=0, bits_avail=8, peek=0xABFF. Pulse marker_ack → bits_avail=0, marker_valid=0, byte_ready=1.
4. Feed 0xFF, 0xFF, 0xFF, 0xD0 → marker_code=0xD0, bits_avail=0, byte_count=4. Fill bytes append nothing.
5. Hold byte_valid with 5 bytes queued → after 4 bytes bits_avail=32 and byte_ready=0. Consume 8 → next cycle byte_ready=1, fifth byte accepted, bits_avail=32 again. Also: consume 8 while appending at bits_avail=24 → bits_avail=24.
6. bits_avail=3, consume_n=5 → no state change, consume_err high for exactly one cycle. Assert rst mid-stream → all outputs return to reset values asynchronously.
